// File: rtl/code_lock_param_if.sv
// rtl/code_lock_param_if.sv - keypad command/digit strobes and lock status bundle
//   master: drives cmd_valid, cmd, digit_valid, digit; observes status
//   slave : the lock; observes strobes; drives unlock, err, prog_done,
//           alarm, lockout, err_cnt, curr
interface code_lock_param_if #(
  parameter int DIGIT_W = 4,
  parameter int MAX_ERR = 3
);
  localparam int ERR_W = $clog2(MAX_ERR + 1);

  logic               cmd_valid;
  logic [1:0]         cmd;
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               unlock;
  logic               err;
  logic               prog_done;
  logic               alarm;
  logic               lockout;
  logic [ERR_W-1:0]   err_cnt;
  logic [2:0]         curr;

  modport master (
    output cmd_valid, cmd, digit_valid, digit,
    input  unlock, err, prog_done, alarm, lockout, err_cnt, curr
  );

  modport slave (
    input  cmd_valid, cmd, digit_valid, digit,
    output unlock, err, prog_done, alarm, lockout, err_cnt, curr
  );
endinterface

// File: rtl/code_lock_param.sv
// rtl/code_lock_param.sv - parametrised keypad code lock with alarm and timed lockout
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : code_lock_param_if.slave
//           in : cmd_valid, cmd (0 VERIFY,1 PROG,2 RELOCK,3 ABORT), digit_valid, digit
//           out: unlock, err, prog_done, alarm, lockout, err_cnt, curr (all registered)
module code_lock_param #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_ERR     = 3,
  parameter int LOCKOUT_CYC = 1024,
  parameter logic [DIGIT_W*CODE_LEN-1:0] ADMIN_CODE = 16'h2F2F,
  parameter logic [DIGIT_W*CODE_LEN-1:0] RESET_CODE = '0
) (
  input logic              clk,
  input logic              rst_n,
  code_lock_param_if.slave bus
);
  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int ERR_W  = $clog2(MAX_ERR + 1);
  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TMR_W  = $clog2(LOCKOUT_CYC + 1);

  localparam logic [1:0] CMD_VERIFY = 2'd0;
  localparam logic [1:0] CMD_PROG   = 2'd1;
  localparam logic [1:0] CMD_RELOCK = 2'd2;
  localparam logic [1:0] CMD_ABORT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_VERIFY  = 3'd1,
    S_PROG    = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               user_ok;
  logic               admin_ok;
  logic [CODE_W-1:0]  user_code;
  logic [CODE_W-1:0]  shadow;
  logic [TMR_W-1:0]   timer;
  logic               unlock_q;
  logic               err_q;
  logic               prog_done_q;
  logic               alarm_q;
  logic               lockout_q;
  logic [ERR_W-1:0]   err_cnt_q;

  logic [DIGIT_W-1:0] user_dig;
  logic [DIGIT_W-1:0] admin_dig;
  logic               last_digit;
  logic               user_hit;
  logic               admin_hit;
  logic [ERR_W-1:0]   err_cnt_inc;
  logic               err_limit;
  logic [CODE_W-1:0]  shadow_next;

  // Expected digit at the current index; the first-entered digit is the MS slice.
  always_comb begin
    user_dig  = '0;
    admin_dig = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx == IDX_W'(i)) begin
        user_dig  = user_code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        admin_dig = ADMIN_CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign last_digit  = (idx == IDX_W'(CODE_LEN - 1));
  assign user_hit    = user_ok  && (bus.digit == user_dig);
  assign admin_hit   = admin_ok && (bus.digit == admin_dig);
  assign err_cnt_inc = (err_cnt_q == ERR_W'(MAX_ERR)) ? err_cnt_q : err_cnt_q + ERR_W'(1);
  assign err_limit   = (err_cnt_inc >= ERR_W'(MAX_ERR));

  // New digits enter at the LS end so the first digit ends up in the MS slice.
  generate
    if (CODE_LEN > 1) begin : g_shift
      assign shadow_next = {shadow[CODE_W-DIGIT_W-1:0], bus.digit};
    end else begin : g_single
      assign shadow_next = bus.digit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      user_ok     <= 1'b0;
      admin_ok    <= 1'b0;
      user_code   <= RESET_CODE;
      shadow      <= '0;
      timer       <= '0;
      unlock_q    <= 1'b0;
      err_q       <= 1'b0;
      prog_done_q <= 1'b0;
      alarm_q     <= 1'b0;
      lockout_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_q       <= 1'b0;
      prog_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd == CMD_VERIFY) begin
              state    <= S_VERIFY;
              idx      <= '0;
              user_ok  <= 1'b1;
              admin_ok <= 1'b1;
            end else if (bus.cmd != CMD_ABORT) begin
              err_q <= 1'b1;
            end
          end
        end

        S_VERIFY: begin
          // A command in the same cycle as a digit wins; the digit is dropped.
          if (bus.cmd_valid) begin
            if (bus.cmd == CMD_ABORT) begin
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.digit_valid) begin
            if (last_digit) begin
              idx <= '0;
              if (admin_hit) begin
                state     <= S_OPEN;
                unlock_q  <= 1'b1;
                err_cnt_q <= '0;
                alarm_q   <= 1'b0;
              end else if (user_hit && !alarm_q) begin
                state     <= S_OPEN;
                unlock_q  <= 1'b1;
                err_cnt_q <= '0;
              end else begin
                err_q     <= 1'b1;
                err_cnt_q <= err_cnt_inc;
                if (err_limit) begin
                  alarm_q   <= 1'b1;
                  state     <= S_LOCKOUT;
                  lockout_q <= 1'b1;
                  timer     <= TMR_W'(LOCKOUT_CYC);
                end else begin
                  state <= S_IDLE;
                end
              end
            end else begin
              idx      <= idx + IDX_W'(1);
              user_ok  <= user_hit;
              admin_ok <= admin_hit;
            end
          end
        end

        S_OPEN: begin
          if (bus.cmd_valid) begin
            case (bus.cmd)
              CMD_PROG: begin
                state <= S_PROG;
                idx   <= '0;
              end
              CMD_RELOCK: begin
                state    <= S_IDLE;
                unlock_q <= 1'b0;
              end
              CMD_VERIFY: err_q <= 1'b1;
              default: ;
            endcase
          end
        end

        S_PROG: begin
          if (bus.cmd_valid) begin
            if (bus.cmd == CMD_ABORT) begin
              state <= S_OPEN;
              idx   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.digit_valid) begin
            if (last_digit) begin
              // Commit the whole code at once so a partial entry never takes effect.
              user_code   <= shadow_next;
              prog_done_q <= 1'b1;
              state       <= S_OPEN;
              idx         <= '0;
            end else begin
              shadow <= shadow_next;
              idx    <= idx + IDX_W'(1);
            end
          end
        end

        S_LOCKOUT: begin
          // Loaded with LOCKOUT_CYC on entry; leaving at 1 gives exactly that many cycles.
          if (timer == TMR_W'(1)) begin
            state     <= S_IDLE;
            lockout_q <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          unlock_q  <= 1'b0;
          lockout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.err       = err_q;
  assign bus.prog_done = prog_done_q;
  assign bus.alarm     = alarm_q;
  assign bus.lockout   = lockout_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.curr      = state;
endmodule

// File: doc/code_lock_param.md
# code_lock_param

Parametrised keypad code lock for the access-control path. Accepts `CODE_LEN` digits of `DIGIT_W` bits each and compares them against a programmable user code and a fixed admin code. Tracks failed attempts, raises an alarm with a timed lockout after `MAX_ERR` failures, and allows the user code to be reprogrammed only while open. Sits between the keypad debouncer/decoder and the actuator driver.

## Interface
- `DIGIT_W`, 4, bits per digit.
- `CODE_LEN`, 4, digits per code; ≥1.
- `MAX_ERR`, 3, consecutive failures that trigger alarm; ≥1.
- `LOCKOUT_CYC`, 1024, lockout duration in clk cycles; ≥1.
- `ADMIN_CODE`, 16'h2F2F, admin code; width `DIGIT_W*CODE_LEN`; first-entered digit in the MS slice.
- `RESET_CODE`, 0, user code loaded at reset; same width and ordering as `ADMIN_CODE`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command strobe, one cycle.
- `cmd`  in  2  0=VERIFY, 1=PROG, 2=RELOCK, 3=ABORT.
- `digit_valid`  in  1  digit strobe, one cycle.
- `digit`  in  `DIGIT_W`  digit value.
- `unlock`  out  1  level; high in OPEN and PROG.
- `err`  out  1  one-cycle pulse on failed verify or illegal command.
- `prog_done`  out  1  one-cycle pulse on user-code commit.
- `alarm`  out  1  level; set on reaching `MAX_ERR`; cleared only by admin success or reset.
- `lockout`  out  1  level; high in LOCKOUT.
- `err_cnt`  out  `$clog2(MAX_ERR+1)`  consecutive failures, saturating at `MAX_ERR`.
- `curr`  out  3  state: IDLE=0, VERIFY=1, PROG=2, OPEN=3, LOCKOUT=4.

## Operation
- Reset (`rst_n`=0 at an edge) sets:
  - state IDLE;
  - `unlock`, `err`, `prog_done`, `alarm`, `lockout`, `err_cnt` to 0;
  - user code to `RESET_CODE`;
  - digit index, match flags and timer cleared.
- Reset mid-entry discards the partial entry.
- IDLE:
  - VERIFY → VERIFY, index 0, user_ok=admin_ok=1.
  - PROG or RELOCK → `err` pulse, stay IDLE.
  - ABORT is a no-op.
- VERIFY:
  - Each digit clears user_ok or admin_ok on mismatch at the current index. There is no early reject; all `CODE_LEN` digits are always consumed.
  - On the last digit:
    - admin_ok → OPEN, `err_cnt`=0, `alarm`=0.
    - Else user_ok and !`alarm` → OPEN, `err_cnt`=0.
    - Else `err` pulse and `err_cnt` incremented (saturating). If the new count ≥ `MAX_ERR`: `alarm`=1, LOCKOUT, timer=`LOCKOUT_CYC`. Otherwise → IDLE.
  - If both codes match, the admin path is taken.
  - ABORT → IDLE with no count change. Other commands → `err` pulse, entry continues.
- OPEN:
  - PROG → PROG, index 0.
  - RELOCK → IDLE.
  - VERIFY → `err` pulse, stay.
  - Digits are ignored.
- PROG:
  - Digits shift into a shadow register.
  - On the last digit, the shadow commits atomically to the user code, `prog_done` pulses, → OPEN.
  - ABORT → OPEN; user code unchanged.
- LOCKOUT:
  - All digits and commands are ignored (no `err`).
  - Timer decrements each cycle; → IDLE when it reaches 1.
  - `alarm` stays set afterwards, so only the admin code can open. Another failure re-enters LOCKOUT.
- A command and a digit in the same cycle: the command wins and the digit is dropped.
- Digits are ignored in IDLE and OPEN.

## Timing
- All outputs are registered.
- After the edge sampling the last digit:
  - `unlock` is high on the next cycle;
  - `err`, `prog_done` and `lockout` change on that same next cycle.
- `err` and `prog_done` are exactly one cycle wide.
- `lockout` is high for exactly `LOCKOUT_CYC` cycles; `curr`=0 on the following cycle.
- Strobes may arrive every cycle; there is no backpressure.
- `curr` reflects the registered state.

## Test plan
- Reset, then VERIFY + digits 0,0,0,0 → `unlock`=1 one cycle after the 4th digit; `curr`=3; `err_cnt`=0.
- From OPEN: PROG + 1,2,3,4 → `prog_done` pulse; RELOCK; VERIFY 1,2,3,4 → `unlock`=1; VERIFY 0,0,0,0 (after relock) → `err` pulse, `err_cnt`=1.
- Three wrong verifies → `alarm`=1, `lockout` high for exactly 1024 cycles with digits ignored; then the correct user code → `err` and a return to LOCKOUT; then admin 2,F,2,F → `unlock`=1, `alarm`=0, `err_cnt`=0.
- PROG with 2 digits then ABORT → `curr`=3, old code still verifies; ABORT mid-VERIFY → IDLE, `err_cnt` unchanged.
- `cmd_valid` and `digit_valid` in the same cycle in VERIFY → digit dropped, index unchanged; PROG in IDLE → `err` pulse, `curr`=0.
- `rst_n`=0 mid-PROG → next cycle all outputs 0, `curr`=0, user code = `RESET_CODE`.
